// File: rtl/digit_serial_adder.sv
// Digit-serial adder: sums two WIDTH-bit operands plus carry-in, DIGIT bits per clock,
// behind valid/ready handshakes on the operand and result sides.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             InC,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] R,
  output logic             OutC,
  output logic             Ovf
);

  // state | meaning
  // IDLE  | waiting for operands, InReady high
  // RUN   | adding one digit per cycle, LSB digit first
  // DONE  | result presented, waiting for OutReady
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, part_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] a_nxt, b_nxt, part_nxt;
  logic             last;
  logic             c_msb;

  // Operands shift right so the active digit is always in the low DIGIT bits.
  always_comb begin
    dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    a_nxt    = WIDTH'({{DIGIT{1'b0}}, a_q} >> DIGIT);
    b_nxt    = WIDTH'({{DIGIT{1'b0}}, b_q} >> DIGIT);
    part_nxt = WIDTH'({dsum[DIGIT-1:0], part_q} >> DIGIT);
    last     = (cnt_q == CW'(NDIG - 1));
    c_msb    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    InReady  = 1'b0;
    OutValid = 1'b0;
    case (state_q)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        OutValid = 1'b1;
        if (OutReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      R       <= '0;
      OutC    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            a_q     <= In1;
            b_q     <= In2;
            carry_q <= InC;
            cnt_q   <= '0;
            part_q  <= '0;
          end
        end
        RUN: begin
          a_q     <= a_nxt;
          b_q     <= b_nxt;
          part_q  <= part_nxt;
          carry_q <= dsum[DIGIT];
          if (last) begin
            cnt_q <= '0;
            R     <= part_nxt;
            OutC  <= dsum[DIGIT];
            Ovf   <= c_msb ^ dsum[DIGIT];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
